rho_rotate_stage: RTL and testbench
===================================

// Module: rho_rotate_stage
// PURPOSE
//  Keccak rho step. Directly downstream of the column-parity (theta) stage.
//  - Captures the 64 theta-output slices (25 bits each) from that stage's output stream.
//  - Rotates each of the 25 lanes by its fixed rho offset, serially, one bit per cycle.
//  - Streams the rotated state out slice by slice to the next (pi) stage.
// PARAMETERS
//  W      64  lane length in bits (power of 2); equals the slices per state
//  LOG_W  6   log2(W); width of the slice and rotate counters
// PORTS
//  clk       in   1   single clock; all state changes on its rising edge
//  rst       in   1   synchronous, active-low reset
//  start     in   1   begin a new state; sampled only in Idle
//  inValid   in   1   inSlice valid this cycle (theta stage output strobe)
//  inSlice   in   25  slice z; bit i = lane i, with i = x + 5*y
//  ready     out  1   high only in Idle
//  outReady  out  1   one-cycle pulse immediately before the output burst
//  outValid  out  1   high during the 64 Output cycles
//  outSlice  out  25  rotated slice z during Output; 0 otherwise
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=Idle, sliceCnt=0, rotCnt=0.
//   - Outputs after reset: ready=1, outReady=0, outValid=0, outSlice=0.
//   - Lane contents are not reset.
//  FSM: Idle -> Load -> Rotate -> Inform -> Output -> Idle.
//   Idle:   ready=1; start=1 -> Load, clear sliceCnt.
//   Load:   if inValid: lane[i][sliceCnt] <= inSlice[i] for all i; sliceCnt++.
//           Cycles with inValid=0 leave everything unchanged (gaps allowed).
//           Accepting slice W-1 -> Rotate; sliceCnt wraps to 0; clear rotCnt.
//   Rotate: W-1 cycles, rotCnt = 0..W-2.
//           lane i rotates left by 1 (lane[z] <= lane[z-1 mod W]) iff rotCnt < R[i] mod W.
//           At rotCnt == W-2 -> Inform.
//   Inform: outReady=1 for exactly one cycle; sliceCnt=0 -> Output.
//   Output: outValid=1; outSlice[i] = lane[i][sliceCnt]; sliceCnt++ each cycle.
//           After slice W-1 -> Idle. No backpressure.
//  Offsets R[0..24] (i = x + 5y):
//   0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14
//  Net effect: out lane[i][z] = in lane[i][(z - R[i]) mod W].
//  Latency, start to first outValid (no input gaps): 1 + 64 + 63 + 1 = 129 cycles.
//  Boundaries:
//   - start outside Idle is ignored.
//   - inValid outside Load is ignored.
//   - rst=0 in any state -> Idle next edge; a partial state is discarded.
//   - Slice counter wraps W-1 -> 0; rotation wraps bit W-1 -> bit 0.
//   - Lanes with R=0 (lane 0) pass through unchanged.
// STRUCTURE
//  Shared package (keccak_pkg):
//   - state encodings (Idle, Load, Rotate, Inform, Output);
//   - RHO_OFFSET[25] constant table;
//   - lane count 25 and width W.
//  Sub-module rho_lane_reg, instantiated 25x with its offset as a parameter:
//   - W-bit register;
//   - write-bit-at-index port (for Load);
//   - rotate-left-by-1 enable;
//   - read-bit-at-index port (for Output).
//  Top level holds: FSM, sliceCnt, rotCnt, rotate-enable compare per lane.
// TESTING
//  1. Lane 2 only, bit z=0 set, start, 64 back-to-back slices
//     -> outReady pulse at cycle 129; Output slice 62 bit 2 = 1; all else 0.
//  2. Lane 1, bit z=63 set -> wraps: Output slice 0 bit 1 = 1; all else 0.
//  3. All-ones input -> all 64 output slices = 25'h1FFFFFF.
//     All-zero input -> all 64 output slices = 0.
//  4. Random state with inValid deasserted every 3rd cycle in Load
//     -> output matches reference model a'[i][z] = a[i][(z-R[i]) mod 64];
//        latency grows by the number of gap cycles only.
//  5. start pulsed during Rotate and Output -> ignored; one burst of 64 outValid only.
//  6. rst=0 at rotCnt=30 -> Idle next edge, ready=1, outValid=0;
//     a fresh run afterwards produces a correct result.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the rho stage: lane geometry, FSM encoding
// and the per-lane rho rotation offsets.
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int LANE_LOG_W = 6;
  localparam int NUM_LANES  = 25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ROTATE = 3'd2,
    ST_INFORM = 3'd3,
    ST_OUTPUT = 3'd4
  } rho_state_e;

  // Indexed by lane i = x + 5*y; all values are already reduced mod LANE_W.
  localparam logic [LANE_LOG_W-1:0] RHO_OFFSET [NUM_LANES] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic logic rho_rot_active(input logic [LANE_LOG_W-1:0] rot_cnt,
                                          input logic [LANE_LOG_W-1:0] offset);
    return (rot_cnt < offset);
  endfunction

endpackage

// File: rtl/rho_lane_reg.sv
// One Keccak lane: bit-addressed write for loading, rotate-left-by-one for
// rho, and bit-addressed read for streaming out. Contents are never reset.
module rho_lane_reg #(
  parameter int W     = 64,
  parameter int LOG_W = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LOG_W-1:0] wr_idx,
  input  logic             wr_bit,
  input  logic             rot_en,
  input  logic [LOG_W-1:0] rd_idx,
  output logic             rd_bit
);

  logic [W-1:0] lane_q;
  logic [W-1:0] lane_d;

  always_comb begin
    lane_d = lane_q;
    if (wr_en) begin
      lane_d[wr_idx] = wr_bit;
    end else if (rot_en) begin
      // bit z takes bit z-1; bit W-1 wraps round into bit 0
      lane_d = {lane_q[W-2:0], lane_q[W-1]};
    end else begin
      lane_d = lane_q;
    end
  end

  always_ff @(posedge clk) begin
    lane_q <= lane_d;
  end

  assign rd_bit = lane_q[rd_idx];

endmodule

// File: rtl/rho_rotate_stage.sv
// Keccak rho stage: captures 64 theta slices, rotates every lane serially by
// its rho offset, then streams the rotated state out slice by slice.
module rho_rotate_stage
  import keccak_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int LOG_W = LANE_LOG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 inValid,
  input  logic [NUM_LANES-1:0] inSlice,
  output logic                 ready,
  output logic                 outReady,
  output logic                 outValid,
  output logic [NUM_LANES-1:0] outSlice
);

  rho_state_e           state_q, state_d;
  logic [LOG_W-1:0]     slice_cnt_q, slice_cnt_d;
  logic [LOG_W-1:0]     rot_cnt_q, rot_cnt_d;
  logic                 ready_q, ready_d;
  logic                 out_ready_q, out_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [NUM_LANES-1:0] out_slice_q, out_slice_d;
  logic                 lane_wr_en;
  logic [NUM_LANES-1:0] rot_en;
  logic [NUM_LANES-1:0] rd_bits;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign rot_en[i] = (state_q == ST_ROTATE) && rho_rot_active(rot_cnt_q, RHO_OFFSET[i]);

    rho_lane_reg #(.W(W), .LOG_W(LOG_W)) u_lane (
      .clk    (clk),
      .wr_en  (lane_wr_en),
      .wr_idx (slice_cnt_q),
      .wr_bit (inSlice[i]),
      .rot_en (rot_en[i]),
      .rd_idx (slice_cnt_q),
      .rd_bit (rd_bits[i])
    );
  end

  // Outputs are computed for the next state so every port comes from a flop.
  always_comb begin
    state_d     = state_q;
    slice_cnt_d = slice_cnt_q;
    rot_cnt_d   = rot_cnt_q;
    ready_d     = 1'b0;
    out_ready_d = 1'b0;
    out_valid_d = 1'b0;
    out_slice_d = '0;
    lane_wr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          slice_cnt_d = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (inValid) begin
          lane_wr_en  = 1'b1;
          slice_cnt_d = slice_cnt_q + LOG_W'(1);
          if (slice_cnt_q == LOG_W'(W - 1)) begin
            state_d   = ST_ROTATE;
            rot_cnt_d = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ROTATE: begin
        rot_cnt_d = rot_cnt_q + LOG_W'(1);
        if (rot_cnt_q == LOG_W'(W - 2)) begin
          state_d     = ST_INFORM;
          out_ready_d = 1'b1;
          slice_cnt_d = '0;
        end else begin
          state_d = ST_ROTATE;
        end
      end
      ST_INFORM: begin
        state_d     = ST_OUTPUT;
        out_valid_d = 1'b1;
        out_slice_d = rd_bits;
        slice_cnt_d = slice_cnt_q + LOG_W'(1);
      end
      ST_OUTPUT: begin
        // slice_cnt_q is the next slice to present; back at 0 means all W are out
        if (slice_cnt_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_slice_d = rd_bits;
          slice_cnt_d = slice_cnt_q + LOG_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      slice_cnt_q <= '0;
      rot_cnt_q   <= '0;
      ready_q     <= 1'b1;
      out_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_slice_q <= '0;
    end else begin
      state_q     <= state_d;
      slice_cnt_q <= slice_cnt_d;
      rot_cnt_q   <= rot_cnt_d;
      ready_q     <= ready_d;
      out_ready_q <= out_ready_d;
      out_valid_q <= out_valid_d;
      out_slice_q <= out_slice_d;
    end
  end

  assign ready    = ready_q;
  assign outReady = out_ready_q;
  assign outValid = out_valid_q;
  assign outSlice = out_slice_q;

endmodule

// File: tb/tb_rho_rotate_stage.sv
// Scoreboard bench for rho_rotate_stage: expected slices come from the rho
// definition a'[i][z] = a[i][(z - R[i]) mod 64] and are checked by a monitor.
module tb_rho_rotate_stage;

  localparam int W  = 64;
  localparam int NL = 25;
  localparam int R_TAB [NL] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                                25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic [NL-1:0] inSlice = '0;
  logic          ready, outReady, outValid;
  logic [NL-1:0] outSlice;

  rho_rotate_stage dut (
    .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inSlice(inSlice),
    .ready(ready), .outReady(outReady), .outValid(outValid), .outSlice(outSlice)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [NL-1:0] exp_q [$];
  bit   [W-1:0]  lanes [NL];
  int            start_cyc = 0;
  int            exp_latency = 0;
  int            valid_total = 0;
  bit            mon_en = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [NL-1:0] exp_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every outValid, and check framing signals.
  always @(negedge clk) begin
    if (mon_en) begin
      if (outValid === 1'b1) begin
        valid_total++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_slice: got 0x%0h with no slice expected (cycle %0d)", outSlice, cyc);
        end else begin
          exp_s = exp_q.pop_front();
          check("slice", 32'(outSlice), 32'(exp_s));
        end
        if (prev_valid !== 1'b1) begin
          check("outready_before_burst", 32'(prev_ready), 32'd1);
          check("latency", 32'(cyc - start_cyc + 1), 32'(exp_latency));
        end
      end else begin
        check("idle_slice_zero", 32'(outSlice), 32'd0);
      end
      if (outReady === 1'b1) check("outready_single", 32'(prev_ready), 32'd0);
      prev_valid <= outValid;
      prev_ready <= outReady;
    end
  end

  task automatic set_lanes(input int mode);
    for (int i = 0; i < NL; i++) begin
      case (mode)
        0: lanes[i] = '0;
        1: lanes[i] = '1;
        default: lanes[i] = {$urandom, $urandom};
      endcase
    end
  endtask

  // One full pass; push=0 loads only (used by the reset test).
  task automatic run(input bit gaps, input bit spam, input bit push);
    int            z, k, ngap, base_total;
    logic [NL-1:0] s;
    z = 0; k = 0; ngap = 0;
    if (push) begin
      for (int oz = 0; oz < W; oz++) begin
        for (int i = 0; i < NL; i++) s[i] = lanes[i][(oz - R_TAB[i] + W) % W];
        exp_q.push_back(s);
      end
    end
    base_total = valid_total;
    check("ready_before_start", 32'(ready), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    while (z < W) begin
      @(negedge clk);
      start = 1'b0;
      s = NL'($urandom);
      if (gaps && (k % 3 == 2)) begin
        inValid = 1'b0;
        ngap++;
      end else begin
        inValid = 1'b1;
        for (int i = 0; i < NL; i++) s[i] = lanes[i][z];
        z++;
      end
      inSlice = s;
      @(posedge clk);
      k++;
    end
    exp_latency = 129 + ngap;
    @(negedge clk);
    inValid = 1'b0;
    if (push) begin
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
        @(negedge clk);
        if (spam && (k < 60 || (k >= 66 && k < 110))) begin
          start   = 1'($urandom_range(0, 1));
          inValid = 1'($urandom_range(0, 1));
          inSlice = NL'($urandom);
        end else begin
          start   = 1'b0;
          inValid = 1'b0;
        end
        k++;
      end
      start = 1'b0;
      inValid = 1'b0;
      check("burst_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (spam ? 200 : 4) @(negedge clk);
      check("burst_len", 32'(valid_total - base_total), 32'd64);
      check("ready_after_burst", 32'(ready), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_outready", 32'(outReady), 32'd0);
    check("reset_outvalid", 32'(outValid), 32'd0);
    check("reset_outslice", 32'(outSlice), 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    set_lanes(0); lanes[2][0] = 1'b1;      run(1'b0, 1'b0, 1'b1);
    set_lanes(0); lanes[1][W-1] = 1'b1;    run(1'b0, 1'b0, 1'b1);
    set_lanes(1);                          run(1'b0, 1'b0, 1'b1);
    set_lanes(0);                          run(1'b0, 1'b0, 1'b1);
    set_lanes(2);                          run(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      set_lanes(2);                        run(1'b1, 1'b0, 1'b1);
    end
    set_lanes(2);                          run(1'b0, 1'b1, 1'b1);

    // Abort mid-rotation: rot counter is 30 in the cycle where rst is low.
    set_lanes(2);
    run(1'b0, 1'b0, 1'b0);
    while (cyc < start_cyc + 94) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_outvalid", 32'(outValid), 32'd0);
    check("abort_outready", 32'(outReady), 32'd0);
    check("abort_outslice", 32'(outSlice), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    set_lanes(2);                          run(1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
